// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit for the execute stage
//
// Accepts MULT/MULTU/DIV/DIVU requests from an idle state, stalls execute
// while busy, and presents {hi,lo} with a done flag until the pipeline moves.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active low
//   start      in   1      multiply/divide request, held while E stalls
//   mulOrdiv   in   1      0 = multiply, 1 = divide
//   mdIsSign   in   1      1 = signed operands
//   flush      in   1      abort the current operation
//   stall_in   in   1      pipeline stalled by another source
//   a          in   WIDTH  dividend / multiplicand
//   b          in   WIDTH  divisor / multiplier
//   stall_req  out  1      stall execute
//   done       out  1      hi/lo valid this cycle
//   hi         out  WIDTH  product high half / remainder
//   lo         out  WIDTH  product low half / quotient

module md_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mulOrdiv,
  input  logic             mdIsSign,
  input  logic             flush,
  input  logic             stall_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + MUL_LAT) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sign;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_idle;
  logic             w_busy;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_op_sign;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_a_mag_in;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic             w_neg_q;
  logic             w_neg_r;
  logic             w_dz;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;

  assign w_idle = (r_state == S_IDLE);
  assign w_busy = (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);

  // With MUL_LAT==1 the product is taken straight from the inputs in the
  // accept cycle, so the multiplier sees live operands while idle.
  assign w_op_a    = w_idle ? a : r_a;
  assign w_op_b    = w_idle ? b : r_b;
  assign w_op_sign = w_idle ? mdIsSign : r_sign;
  assign w_ext_a   = {{WIDTH{w_op_sign & w_op_a[WIDTH-1]}}, w_op_a};
  assign w_ext_b   = {{WIDTH{w_op_sign & w_op_b[WIDTH-1]}}, w_op_b};
  assign w_prod    = w_ext_a * w_ext_b;

  assign w_a_mag_in = (mdIsSign & a[WIDTH-1]) ? -a : a;
  assign w_b_mag    = (r_sign & r_b[WIDTH-1]) ? -r_b : r_b;

  // Restoring step: the quotient register starts as |a| and shifts its top
  // bit into the partial remainder while quotient bits fill in from below.
  // The partial remainder stays below 2*|b|, so the borrow bit of the
  // (WIDTH+1)-bit difference is exactly "does not fit".
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, w_b_mag};
  assign w_fits  = ~w_diff[WIDTH];

  assign w_neg_q  = r_sign & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r  = r_sign & r_a[WIDTH-1];
  assign w_dz     = (r_b == '0);
  // Divide by zero bypasses sign fixing so both flavours give hi=a, lo=ones.
  assign w_fix_hi = w_dz ? r_a : (w_neg_r ? -r_rem : r_rem);
  assign w_fix_lo = w_dz ? {WIDTH{1'b1}} : (w_neg_q ? -r_quo : r_quo);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_sign <= mdIsSign;
            r_cnt  <= '0;
            if (mulOrdiv) begin
              r_quo   <= w_a_mag_in;
              r_rem   <= '0;
              r_state <= S_DIV;
            end else if (MUL_LAT == 1) begin
              r_hi    <= w_prod[2*WIDTH-1:WIDTH];
              r_lo    <= w_prod[WIDTH-1:0];
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DIV: begin
          r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_fits};
          if (r_cnt == DIV_LAST) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          // A held start is ignored here; it is re-accepted from IDLE.
          if (!stall_in) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_req = rst & ~flush & ((start & w_idle) | w_busy);
  assign done      = r_done & ~flush;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule
